// File: rtl/pxs_color_sequencer.sv
// Frame-synchronous colour sequencer for a constant-colour pixel-stream layer.
// Steps through a shadowed {colour, frames} table, advancing on VSync frame boundaries.
module pxs_color_sequencer #(
  parameter int         N_ENTRIES     = 4,
  parameter logic       VS_POL        = 1'b0,
  parameter logic [2:0] DEFAULT_COLOR = 3'b001
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic [22:0] VGAStr_i,
  output logic [25:0] RGBStr_o,
  input  logic        enable,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [2:0]  cfg_color,
  input  logic [7:0]  cfg_frames,
  input  logic        cfg_commit,
  output logic        cfg_busy,
  output logic [2:0]  entry_o,
  output logic        frame_tick_o
);

  typedef enum logic [1:0] {STOP = 2'd0, ARM = 2'd1, PLAY = 2'd2} state_t;

  localparam logic [2:0] LAST_ENTRY = 3'(N_ENTRIES - 1);

  state_t      state;
  state_t      state_next;
  logic        vs_prev;
  logic        tick;
  logic        pending;
  logic        commit_now;
  logic        advance;
  logic [2:0]  cur_color;
  logic [2:0]  color_next;
  logic [2:0]  entry;
  logic [2:0]  entry_next;
  logic [2:0]  entry_inc;
  logic [7:0]  frame_cnt;
  logic [7:0]  cnt_next;
  logic [2:0]  shadow_color  [8];
  logic [7:0]  shadow_frames [8];
  logic [2:0]  active_color  [8];
  logic [7:0]  active_frames [8];

  assign tick       = (VGAStr_i[1] == VS_POL) && (vs_prev != VS_POL);
  assign commit_now = tick && pending;
  assign advance    = ({1'b0, frame_cnt} + 9'd1) >= {1'b0, active_frames[entry]};
  assign entry_inc  = (entry == LAST_ENTRY) ? 3'd0 : entry + 3'd1;
  assign cfg_busy   = pending;
  assign entry_o    = entry;

  // VSync history and commit-pending flag; the copy tick clears the flag before a new request can set it
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      vs_prev <= ~VS_POL;
      pending <= 1'b0;
    end else begin
      vs_prev <= VGAStr_i[1];
      if (commit_now) begin
        pending <= 1'b0;
      end else if (cfg_commit) begin
        pending <= 1'b1;
      end else begin
        pending <= pending;
      end
    end
  end

  // Shadow and active tables; durations are stored already clamped to at least one frame
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow_color[i]  <= DEFAULT_COLOR;
        shadow_frames[i] <= 8'd1;
        active_color[i]  <= DEFAULT_COLOR;
        active_frames[i] <= 8'd1;
      end
    end else begin
      if (cfg_we && (int'(cfg_addr) < N_ENTRIES)) begin
        shadow_color[cfg_addr]  <= cfg_color;
        shadow_frames[cfg_addr] <= (cfg_frames == 8'd0) ? 8'd1 : cfg_frames;
      end
      if (commit_now) begin
        for (int i = 0; i < 8; i++) begin
          active_color[i]  <= shadow_color[i];
          active_frames[i] <= shadow_frames[i];
        end
      end
    end
  end

  // FSM state and sequencing registers
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      state     <= STOP;
      cur_color <= DEFAULT_COLOR;
      entry     <= 3'd0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_next;
      cur_color <= color_next;
      entry     <= entry_next;
      frame_cnt <= cnt_next;
    end
  end

  // Next-state logic; a low enable always wins over a tick
  always_comb begin
    state_next = state;
    case (state)
      STOP: state_next = enable ? ARM : STOP;
      ARM: begin
        if (!enable) begin
          state_next = STOP;
        end else if (tick) begin
          state_next = PLAY;
        end else begin
          state_next = ARM;
        end
      end
      PLAY:    state_next = enable ? PLAY : STOP;
      default: state_next = STOP;
    endcase
  end

  // Colour, entry and frame-count updates; a commit restarts playback from the new entry 0
  always_comb begin
    color_next = cur_color;
    entry_next = entry;
    cnt_next   = frame_cnt;
    case (state)
      STOP: begin
        color_next = DEFAULT_COLOR;
        entry_next = 3'd0;
        cnt_next   = 8'd0;
      end
      ARM: begin
        entry_next = 3'd0;
        cnt_next   = 8'd0;
        if (enable && tick) begin
          color_next = active_color[0];
        end else begin
          color_next = DEFAULT_COLOR;
        end
      end
      PLAY: begin
        if (!enable) begin
          color_next = DEFAULT_COLOR;
          entry_next = 3'd0;
          cnt_next   = 8'd0;
        end else if (commit_now) begin
          color_next = shadow_color[0];
          entry_next = 3'd0;
          cnt_next   = 8'd0;
        end else if (tick) begin
          if (advance) begin
            color_next = active_color[entry_inc];
            entry_next = entry_inc;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = frame_cnt + 8'd1;
          end
        end else begin
          cnt_next = frame_cnt;
        end
      end
      default: begin
        color_next = DEFAULT_COLOR;
        entry_next = 3'd0;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Output stream: one-cycle delayed VGA field with colour on active pixels
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      RGBStr_o     <= 26'd0;
      frame_tick_o <= 1'b0;
    end else begin
      RGBStr_o     <= {(VGAStr_i[0] ? cur_color : 3'b000), VGAStr_i};
      frame_tick_o <= tick;
    end
  end

endmodule

// File: doc/pxs_color_sequencer.md
# pxs_color_sequencer

Frame-synchronous controller that sequences the fill colour of a constant-colour pixel-stream layer. It holds a programmable table of up to 8 {colour, duration-in-frames} entries and steps through it, advancing only on frame boundaries detected from VSync. It emits a registered RGB stream of the same format and latency as the constant-colour stage. Table updates are written to a shadow copy and committed atomically at the next frame boundary, so no frame ever shows a partially updated table.

## Interface
- N_ENTRIES, 4, number of table entries used; legal range 1..8.
- VS_POL, 1'b0, VSync active level; 0 means active-low, per 640x480.
- DEFAULT_COLOR, 3'b001, colour driven while not playing; also the reset value of every table colour.
- px_clk  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- VGAStr_i  in  23  input stream: [0] ActiveVideo, [1] VSync, [2] HSync, [12:3] YCoord, [22:13] XCoord.
- RGBStr_o  out  26  output stream: [22:0] is the VGA field delayed by 1 cycle; [25:23] is RGB.
- enable  in  1  level; 1 requests playback, 0 stops playback.
- cfg_we  in  1  shadow-table write strobe.
- cfg_addr  in  3  shadow entry index; writes with cfg_addr ≥ N_ENTRIES are ignored.
- cfg_color  in  3  colour to write.
- cfg_frames  in  8  duration to write; 0 is treated as 1.
- cfg_commit  in  1  single-cycle request to copy the shadow table to the active table.
- cfg_busy  out  1  high from a commit request until the copy is performed.
- entry_o  out  3  index of the active entry being shown.
- frame_tick_o  out  1  one-cycle pulse aligned with the output stream at each frame boundary.

## Operation
- **Frame tick detection**
  - vs_prev is a register holding the previous VSync value.
  - tick = (VSync == VS_POL) && (vs_prev != VS_POL).
  - vs_prev resets to ~VS_POL, so a stream held at the active level out of reset produces one tick.
- **Datapath (every cycle)**
  - RGBStr_o[22:0] <= VGAStr_i[22:0].
  - RGBStr_o[25:23] <= ActiveVideo ? cur_color : 3'b000.
- **FSM states: STOP, ARM, PLAY**
  - STOP: cur_color = DEFAULT_COLOR, entry = 0, frame_cnt = 0. If enable = 1, go to ARM.
  - ARM: on a tick, go to PLAY, load cur_color = active[0].color, entry = 0, frame_cnt = 0. If enable = 0, go to STOP.
  - PLAY, on a tick:
    - If frame_cnt + 1 ≥ max(active[entry].frames, 1): entry <= (entry == N_ENTRIES-1) ? 0 : entry+1, frame_cnt <= 0, cur_color <= colour of the new entry.
    - Otherwise frame_cnt <= frame_cnt + 1.
  - PLAY, enable = 0: go to STOP on the next edge. enable overrides a tick in the same cycle.
- **Commit**
  - cfg_commit sets the pending flag; cfg_busy = pending.
  - On the first tick with pending = 1, in any state: active <= shadow, pending <= 0.
  - If the FSM is in PLAY on that tick, it restarts at entry 0 with frame_cnt = 0 and cur_color = shadow[0].color, ignoring the normal advance.
  - A commit while already pending has no additional effect.
- **Simultaneous events**
  - cfg_we in the copy cycle: the write lands in the shadow table only. The active table receives the pre-write shadow contents.
  - cfg_commit in a tick cycle with pending = 0: the flag is set, and the copy occurs at the following tick.
- **Reset values**
  - RGBStr_o = 0, entry_o = 0, frame_tick_o = 0, cfg_busy = 0.
  - State = STOP, frame_cnt = 0, cur_color = DEFAULT_COLOR.
  - All shadow and active entries = {DEFAULT_COLOR, 1}.
- **Reset mid-frame:** all of the above apply immediately, asynchronously. The stream output is 0 until the first clock edge after reset is released.

## Timing
- **Latency:** 1 cycle from VGAStr_i to RGBStr_o, for both the VGA field and RGB.
- **frame_tick_o:** asserted in the cycle after the tick input cycle, i.e. aligned with the delayed VSync edge on RGBStr_o.
- **Colour change:** cur_color and entry_o update on the edge that ends the tick cycle.
  - The pixel sampled in the tick cycle uses the old colour.
  - The first changed pixel appears 2 cycles after the tick input cycle. This is always inside vertical blanking.
- **Enable low:** DEFAULT_COLOR applies to pixels sampled 1 cycle after enable is seen low.
- **cfg_busy:** rises on the edge after cfg_commit and falls on the edge ending the copy tick.
- **Frame counter:** 8-bit; the maximum duration is 255 frames per entry.

## Test plan
- **Reset defaults:** reset, then 2 frames of stream with enable = 0. Required: RGB = 001 on active pixels, 000 in blanking; entry_o = 0; cfg_busy = 0; frame_tick_o pulses once per frame.
- **Programmed sequence:** write {100,1}, {010,2}, {111,1}, {001,3} to entries 0..3; commit; enable. Required: from frame 2 onward the colours are 100, 010, 010, 111, 001, 001, 001, 100, … and entry_o wraps 3→0.
- **Atomic commit:** during PLAY, write entry 1 = {000,5} and commit mid-frame. Required:
  - The current frame colour is unchanged.
  - cfg_busy is high until the next tick.
  - The next frame shows the entry 0 colour, with entry_o = 0.
- **Write outside the table and zero duration:** with N_ENTRIES = 4, write to addr 5 with frames = 0. Required: no change to entries 0..3. Separately, an entry written with frames = 0 is shown for exactly 1 frame.
- **Stop and rearm:** drop enable mid-frame. Required: the colour is 001 from the next pixel. Raise enable mid-frame. Required: the colour stays 001 until the next tick, then shows entry 0 in PLAY.
- **Async reset during active video:** assert reset at pixel x = 300. Required: RGBStr_o = 0 immediately; state = STOP; table entries = {001,1}.
